// File: rtl/shift_step_ctrl.sv
// Step sequencer for an external barrel shifter: applies a latched shift/rotate
// once every STEP_DIV cycles for a requested number of steps, then reports.
module shift_step_ctrl #(
    parameter int SIZE     = 4,
    parameter int STEP_DIV = 4,
    localparam int AW      = $clog2(SIZE),
    localparam int DW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [SIZE-1:0] data_in,
    input  logic [AW-1:0]   amt_in,
    input  logic            mode_in,
    input  logic [3:0]      steps_in,
    input  logic            abort,
    output logic [SIZE-1:0] shift_a,
    output logic [AW-1:0]   shift_amt,
    output logic            shift_rotate_sel,
    input  logic [SIZE-1:0] shift_y,
    output logic [SIZE-1:0] result,
    output logic [3:0]      step_cnt,
    output logic            busy,
    output logic            done,
    output logic            zero_flag
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q;
    logic [SIZE-1:0] work_q;
    logic [AW-1:0]   amt_q;
    logic            rot_q;
    logic [3:0]      steps_q;
    logic [3:0]      step_cnt_q;
    logic [DW-1:0]   div_cnt_q;
    logic [SIZE-1:0] result_q;
    logic            busy_q;
    logic            ready_q;
    logic            done_q;
    logic            zero_q;

    logic [3:0]      step_cnt_d;
    logic            step_now;
    logic            early_zero;
    logic            last_step;

    assign step_now   = (div_cnt_q == DW'(STEP_DIV - 1));
    assign step_cnt_d = step_cnt_q + 4'd1;
    // Only a logical shift can collapse to zero for good; a rotate never does.
    assign early_zero = !rot_q && (shift_y == '0);
    assign last_step  = (step_cnt_d == steps_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            amt_q      <= '0;
            rot_q      <= 1'b0;
            steps_q    <= '0;
            step_cnt_q <= '0;
            div_cnt_q  <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        work_q     <= data_in;
                        amt_q      <= amt_in;
                        rot_q      <= mode_in;
                        steps_q    <= steps_in;
                        step_cnt_q <= '0;
                        div_cnt_q  <= '0;
                        zero_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        if (steps_in == 4'd0) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= data_in;
                        end else begin
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over a step landing on the same edge.
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (step_now) begin
                        div_cnt_q  <= '0;
                        work_q     <= shift_y;
                        step_cnt_q <= step_cnt_d;
                        if (last_step || early_zero) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= shift_y;
                            zero_q   <= early_zero;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready      = ready_q;
    assign shift_a          = work_q;
    assign shift_amt        = amt_q;
    assign shift_rotate_sel = rot_q;
    assign result           = result_q;
    assign step_cnt         = step_cnt_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign zero_flag        = zero_q;

endmodule

// File: tb/tb_shift_step_ctrl.sv
// Directed bench for shift_step_ctrl with a behavioural 4-bit barrel shifter.
module tb_shift_step_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [3:0] data_in = '0;
    logic [1:0] amt_in = '0;
    logic       mode_in = 1'b0;
    logic [3:0] steps_in = '0;
    logic       abort = 1'b0;
    logic [3:0] shift_a;
    logic [1:0] shift_amt;
    logic       shift_rotate_sel;
    logic [3:0] shift_y;
    logic [3:0] result;
    logic [3:0] step_cnt;
    logic       busy, done, zero_flag;

    int pass_cnt = 0;
    int total_cnt = 0;

    shift_step_ctrl #(.SIZE(4), .STEP_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .data_in(data_in), .amt_in(amt_in), .mode_in(mode_in), .steps_in(steps_in),
        .abort(abort),
        .shift_a(shift_a), .shift_amt(shift_amt), .shift_rotate_sel(shift_rotate_sel),
        .shift_y(shift_y),
        .result(result), .step_cnt(step_cnt),
        .busy(busy), .done(done), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [7:0] dbl;
        dbl = {shift_a, shift_a} >> shift_amt;
        shift_y = shift_rotate_sel ? dbl[3:0] : (shift_a >> shift_amt);
    end

    task automatic chk(input string tag, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Starts a run and waits for done; lat = cycle index of done (0 if never),
    // a5 = shift_a seen in cycle 5. Optional mid-run start pulse and abort.
    task automatic run(input logic [3:0] d, input logic [1:0] a, input logic m,
                       input logic [3:0] s, input int inj_cyc, input int abort_cyc,
                       input int max_cyc, output int lat, output logic [3:0] a5);
        @(negedge clk);
        data_in = d; amt_in = a; mode_in = m; steps_in = s; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        data_in = '0; amt_in = '0; mode_in = 1'b0; steps_in = '0;
        lat = 0;
        a5 = '0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk);
            start_valid = 1'b0;
            abort = 1'b0;
            if (n == 5) a5 = shift_a;
            if (done && lat == 0) lat = n;
            if (lat != 0 && abort_cyc == 0) break;
            if (n == inj_cyc) begin
                data_in = 4'b1111; amt_in = 2'd3; mode_in = 1'b1; steps_in = 4'd1;
                start_valid = 1'b1;
            end
            if (n == abort_cyc) abort = 1'b1;
        end
        start_valid = 1'b0;
        abort = 1'b0;
    endtask

    int lat;
    logic [3:0] a5;

    initial begin
        #12;
        chk("rst_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_shift_a", shift_a, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Rotate 1011 by 1, two steps.
        run(4'b1011, 2'd1, 1'b1, 4'd2, 0, 0, 40, lat, a5);
        chk("rot_a5", a5, 4'b1101);
        chk("rot_lat", lat, 9);
        chk("rot_result", result, 4'b1110);
        chk("rot_steps", step_cnt, 2);
        chk("rot_zero", zero_flag, 0);
        chk("rot_busy_done", busy, 1);
        @(negedge clk);
        chk("rot_done_1cyc", done, 0);
        chk("rot_ready_back", start_ready, 1);

        // Logical shift 1000 by 2, exits early on zero after step 2.
        run(4'b1000, 2'd2, 1'b0, 4'd3, 0, 0, 40, lat, a5);
        chk("shr_a5", a5, 4'b0010);
        chk("shr_lat", lat, 9);
        chk("shr_result", result, 4'b0000);
        chk("shr_steps", step_cnt, 2);
        chk("shr_zero", zero_flag, 1);

        // Logical shift 1111 by 1, three steps, no early exit.
        run(4'b1111, 2'd1, 1'b0, 4'd3, 0, 0, 40, lat, a5);
        chk("shr3_lat", lat, 13);
        chk("shr3_result", result, 4'b0001);
        chk("shr3_steps", step_cnt, 3);
        chk("shr3_zero", zero_flag, 0);

        // Zero steps.
        run(4'b0110, 2'd1, 1'b1, 4'd0, 0, 0, 40, lat, a5);
        chk("zs_lat", lat, 1);
        chk("zs_result", result, 4'b0110);
        chk("zs_steps", step_cnt, 0);

        // Abort in cycle 6 of a 5-step rotate: no done, result kept.
        @(negedge clk);
        run(4'b1011, 2'd1, 1'b1, 4'd5, 0, 6, 30, lat, a5);
        chk("ab_no_done", lat, 0);
        chk("ab_result", result, 4'b0110);
        chk("ab_ready", start_ready, 1);
        chk("ab_busy", busy, 0);
        chk("ab_steps", step_cnt, 1);

        // Start pulse during RUN must be ignored.
        run(4'b1000, 2'd1, 1'b0, 4'd2, 3, 0, 40, lat, a5);
        chk("bz_lat", lat, 9);
        chk("bz_result", result, 4'b0010);
        chk("bz_steps", step_cnt, 2);
        chk("bz_mode", shift_rotate_sel, 0);

        // Reset mid-run, in cycle 3.
        @(negedge clk);
        data_in = 4'b1011; amt_in = 2'd1; mode_in = 1'b1; steps_in = 4'd4; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_ready", start_ready, 1);
        chk("mr_shift_a", shift_a, 0);
        chk("mr_amt", shift_amt, 0);
        chk("mr_rot", shift_rotate_sel, 0);
        chk("mr_result", result, 0);
        chk("mr_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run(4'b0101, 2'd2, 1'b0, 4'd0, 0, 0, 40, lat, a5);
        chk("mr_new_lat", lat, 1);
        chk("mr_new_result", result, 4'b0101);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
